// File: rtl/button_repeater.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : button_repeater                                              |
// | Description : Turns two raw push-buttons (up/down) into clean one-cycle    |
// |               inc/dec/clr pulses for the number stage. Each button is      |
// |               synchronised and debounced. A press emits a first pulse and  |
// |               then auto-repeats while the button is held. Holding both     |
// |               buttons for CLEAR_HOLD cycles emits a single clr pulse.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Ports
//   dyn_clk    in   dynamic clock, shared with the number stage
//   reset      in   asynchronous, active-high reset
//   btn_up     in   raw up button (asynchronous, active-high)
//   btn_down   in   raw down button (asynchronous, active-high)
//   inc        out  one-cycle increment pulse
//   dec        out  one-cycle decrement pulse
//   clr        out  one-cycle clear pulse
//   repeating  out  high while auto-repeat is active
//
// Parameters
//   DEBOUNCE       consecutive differing synced samples needed to flip a level
//   REPEAT_DELAY   cycles from the first pulse to the first auto-repeat pulse
//   REPEAT_PERIOD  cycles between auto-repeat pulses
//   CLEAR_HOLD     cycles both buttons must be held before clr
//   CW             width of the debounce and hold timers
module button_repeater #(
  parameter int DEBOUNCE      = 4,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4,
  parameter int CLEAR_HOLD    = 16,
  parameter int CW            = 8
) (
  input  logic dyn_clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic inc,
  output logic dec,
  output logic clr,
  output logic repeating
);

  // Terminal counts. Each timer starts at 0 on entry, so the event fires
  // when the timer reads N-1 on the N-th cycle after entry.
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_HOLD - 1);

  // Bit 1 carries the up button and bit 0 the down button, so the debounced
  // pair reads 10=UP, 01=DOWN, 11=BOTH and 00=NONE.
  logic [1:0] btn_raw;
  logic [1:0] db;

  assign btn_raw = {btn_up, btn_down};

  // --------------------------------------------------------------------------
  // Per-button synchroniser and debouncer
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic          meta_q, meta_d;
      logic          sync_q, sync_d;
      logic          db_q,   db_d;
      logic [CW-1:0] cnt_q,  cnt_d;

      always_comb begin
        meta_d = btn_raw[gi];
        sync_d = meta_q;
        db_d   = db_q;
        cnt_d  = cnt_q;
        if (sync_q == db_q) begin
          // Any sample that agrees with the current level restarts the run.
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          // This is the DEBOUNCE-th differing sample in a row.
          db_d  = sync_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge dyn_clk or posedge reset) begin
        if (reset) begin
          meta_q <= 1'b0;
          sync_q <= 1'b0;
          db_q   <= 1'b0;
          cnt_q  <= '0;
        end else begin
          meta_q <= meta_d;
          sync_q <= sync_d;
          db_q   <= db_d;
          cnt_q  <= cnt_d;
        end
      end

      assign db[gi] = db_q;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Press / repeat / chord state machine
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DELAY  = 3'd1,
    S_REPEAT = 3'd2,
    S_BOTH   = 3'd3,
    S_LOCK   = 3'd4
  } state_t;

  state_t        state_q,     state_d;
  logic [CW-1:0] tmr_q,       tmr_d;
  logic          dir_up_q,    dir_up_d;
  logic          inc_q,       inc_d;
  logic          dec_q,       dec_d;
  logic          clr_q,       clr_d;
  logic          repeating_q, repeating_d;
  logic [CW-1:0] hold_last;

  // DELAY and REPEAT share the same exits and differ only in how long the
  // held button must stay down before the next pulse.
  assign hold_last = (state_q == S_DELAY) ? RD_LAST : RP_LAST;

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    dir_up_d = dir_up_q;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    clr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        case (db)
          2'b10: begin
            inc_d    = 1'b1;
            dir_up_d = 1'b1;
            state_d  = S_DELAY;
            tmr_d    = '0;
          end
          2'b01: begin
            dec_d    = 1'b1;
            dir_up_d = 1'b0;
            state_d  = S_DELAY;
            tmr_d    = '0;
          end
          2'b11: begin
            state_d = S_BOTH;
            tmr_d   = '0;
          end
          default: begin
          end
        endcase
      end

      S_DELAY, S_REPEAT: begin
        if (db == 2'b00) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else if (db == 2'b11) begin
          // The second button joined: start timing a clear chord.
          state_d = S_BOTH;
          tmr_d   = '0;
        end else if (db[1] != dir_up_q) begin
          // Only the opposite button is now down: treat it as a fresh press
          // in the new direction, restarting the initial repeat delay.
          dir_up_d = db[1];
          inc_d    = db[1];
          dec_d    = ~db[1];
          state_d  = S_DELAY;
          tmr_d    = '0;
        end else if (tmr_q == hold_last) begin
          inc_d   = dir_up_q;
          dec_d   = ~dir_up_q;
          state_d = S_REPEAT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_BOTH: begin
        if (db != 2'b11) begin
          // Chord broken before the hold time: abandon it silently.
          state_d = S_LOCK;
          tmr_d   = '0;
        end else if (tmr_q == CLR_LAST) begin
          clr_d   = 1'b1;
          state_d = S_LOCK;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_LOCK: begin
        // A button left down after a chord must not count as a press;
        // wait for a full release first.
        if (db == 2'b00) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // repeating follows the registered state so it changes on the same edge.
  assign repeating_d = (state_d == S_REPEAT);

  always_ff @(posedge dyn_clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      dir_up_q    <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      clr_q       <= 1'b0;
      repeating_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      dir_up_q    <= dir_up_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      clr_q       <= clr_d;
      repeating_q <= repeating_d;
    end
  end

  assign inc       = inc_q;
  assign dec       = dec_q;
  assign clr       = clr_q;
  assign repeating = repeating_q;

endmodule

`default_nettype wire

// File: tb/tb_button_repeater.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_button_repeater                                           |
// | Description : Self-checking bench for button_repeater. Table of press      |
// |               patterns with expected pulse counts, hand-written corner     |
// |               sequences, and random stimulus against a reference model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_button_repeater;

  localparam int DEBOUNCE      = 4;
  localparam int REPEAT_DELAY  = 8;
  localparam int REPEAT_PERIOD = 4;
  localparam int CLEAR_HOLD    = 16;
  localparam int CW            = 8;
  localparam int GAP           = 24;   // idle cycles that always return to IDLE

  logic dyn_clk = 1'b0;
  logic reset;
  logic btn_up;
  logic btn_down;
  logic inc, dec, clr, repeating;

  button_repeater #(
    .DEBOUNCE      (DEBOUNCE),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD),
    .CLEAR_HOLD    (CLEAR_HOLD),
    .CW            (CW)
  ) dut (
    .dyn_clk   (dyn_clk),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .inc       (inc),
    .dec       (dec),
    .clr       (clr),
    .repeating (repeating)
  );

  always #5 dyn_clk = ~dyn_clk;

  int checks = 0;
  int passes = 0;

  // Per-sequence observation counters (edge index counted from seq_begin).
  int seq_cyc, n_inc, n_dec, n_clr, first_inc, first_dec, second_dec;

  // ------------------------------------------------------------------------
  // Reference model: synchroniser as a two-stage delay, debounce as "the last
  // DEBOUNCE synced samples all disagree with the level", and the press logic
  // tracked with absolute cycle numbers of the next scheduled pulse.
  // ------------------------------------------------------------------------
  localparam int M_IDLE = 0, M_HELD = 1, M_CHORD = 2, M_LOCK = 3;
  int        m_now, m_mode, m_next, m_clr_at;
  bit        m_dir_up, m_rep;
  bit        m_s1 [2];
  bit        m_s2 [2];
  bit        m_db [2];
  bit [31:0] m_hist [2];
  bit [3:0]  exp_o;   // {inc, dec, clr, repeating}

  task automatic model_reset();
    m_now = 0; m_mode = M_IDLE; m_next = 0; m_clr_at = 0;
    m_dir_up = 1'b0; m_rep = 1'b0; exp_o = '0;
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_db[b] = 1'b0; m_hist[b] = '0;
    end
  endtask

  task automatic model_press(input bit up_dir);
    m_mode   = M_HELD;
    m_dir_up = up_dir;
    m_rep    = 1'b0;
    m_next   = m_now + REPEAT_DELAY;
    if (up_dir) exp_o[3] = 1'b1; else exp_o[2] = 1'b1;
  endtask

  task automatic model_step();
    bit [1:0]  pair;
    bit [1:0]  raw;
    bit [31:0] mask;
    pair  = {m_db[1], m_db[0]};
    raw   = {btn_up, btn_down};
    mask  = (32'd1 << DEBOUNCE) - 32'd1;
    m_now = m_now + 1;
    exp_o = '0;
    case (m_mode)
      M_IDLE: begin
        if (pair == 2'b10) model_press(1'b1);
        else if (pair == 2'b01) model_press(1'b0);
        else if (pair == 2'b11) begin m_mode = M_CHORD; m_clr_at = m_now + CLEAR_HOLD; end
      end
      M_HELD: begin
        if (pair == 2'b00) m_mode = M_IDLE;
        else if (pair == 2'b11) begin m_mode = M_CHORD; m_clr_at = m_now + CLEAR_HOLD; end
        else if (pair[1] != m_dir_up) model_press(pair[1]);
        else if (m_now == m_next) begin
          if (m_dir_up) exp_o[3] = 1'b1; else exp_o[2] = 1'b1;
          m_rep  = 1'b1;
          m_next = m_now + REPEAT_PERIOD;
        end
      end
      M_CHORD: begin
        if (pair != 2'b11) m_mode = M_LOCK;
        else if (m_now == m_clr_at) begin exp_o[1] = 1'b1; m_mode = M_LOCK; end
      end
      M_LOCK: begin
        if (pair == 2'b00) m_mode = M_IDLE;
      end
      default: m_mode = M_IDLE;
    endcase
    exp_o[0] = (m_mode == M_HELD) && m_rep;
    for (int b = 0; b < 2; b++) begin
      m_hist[b] = {m_hist[b][30:0], m_s2[b]};
      if (m_db[b] ? ((m_hist[b] & mask) == 32'd0) : ((m_hist[b] & mask) == mask))
        m_db[b] = ~m_db[b];
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
  endtask

  // ------------------------------------------------------------------------
  // Checking helpers
  // ------------------------------------------------------------------------
  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  task automatic check_out();
    checks++;
    if ({inc, dec, clr, repeating} === exp_o) passes++;
    else $display("FAIL outputs at %0t: got {inc,dec,clr,rep}=%b, expected %b",
                  $time, {inc, dec, clr, repeating}, exp_o);
  endtask

  task automatic seq_begin();
    seq_cyc = 0; n_inc = 0; n_dec = 0; n_clr = 0;
    first_inc = 0; first_dec = 0; second_dec = 0;
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, then
  // sample the DUT on the falling edge.
  task automatic tick(input bit up, input bit dn);
    btn_up   = up;
    btn_down = dn;
    @(posedge dyn_clk);
    model_step();
    @(negedge dyn_clk);
    seq_cyc++;
    if (inc) begin n_inc++; if (first_inc == 0) first_inc = seq_cyc; end
    if (dec) begin
      n_dec++;
      if (first_dec == 0) first_dec = seq_cyc;
      else if (second_dec == 0) second_dec = seq_cyc;
    end
    if (clr) n_clr++;
    check_out();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({inc, dec, clr, repeating} === 4'b0000) passes++;
    else $display("FAIL async_reset: got {inc,dec,clr,rep}=%b, expected 0000",
                  {inc, dec, clr, repeating});
    model_reset();
    @(posedge dyn_clk);
    @(posedge dyn_clk);
    @(negedge dyn_clk);
    reset = 1'b0;
  endtask

  // ------------------------------------------------------------------------
  // Table: press a pattern for len cycles, then GAP idle cycles; count pulses.
  // ------------------------------------------------------------------------
  typedef struct {
    bit up;
    bit dn;
    int len;
    int n_inc;
    int n_dec;
    int n_clr;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish (%0d of %0d passed)", passes, checks);
    $fatal(1);
  end

  initial begin
    // Debounced level is seen by the press logic for edges 7..len+6.
    tbl[0]  = '{1'b1, 1'b0,  4, 1, 0, 0};  // shortest real press
    tbl[1]  = '{1'b1, 1'b0,  6, 1, 0, 0};
    tbl[2]  = '{1'b0, 1'b1,  2, 0, 0, 0};  // glitch
    tbl[3]  = '{1'b0, 1'b1,  3, 0, 0, 0};  // glitch, one short of debounce
    tbl[4]  = '{1'b0, 1'b1,  4, 0, 1, 0};
    tbl[5]  = '{1'b1, 1'b0,  8, 1, 0, 0};  // released just before first repeat
    tbl[6]  = '{1'b1, 1'b0,  9, 2, 0, 0};  // first repeat at +8
    tbl[7]  = '{1'b1, 1'b0, 12, 2, 0, 0};
    tbl[8]  = '{1'b1, 1'b0, 13, 3, 0, 0};  // second repeat at +12
    tbl[9]  = '{1'b0, 1'b1, 40, 0, 9, 0};  // long hold
    tbl[10] = '{1'b1, 1'b1, 16, 0, 0, 0};  // chord one cycle short
    tbl[11] = '{1'b1, 1'b1, 17, 0, 0, 1};  // chord just long enough
    tbl[12] = '{1'b1, 1'b1, 30, 0, 0, 1};  // single clr however long
    tbl[13] = '{1'b1, 1'b0,  3, 0, 0, 0};

    btn_up = 1'b0; btn_down = 1'b0; reset = 1'b1;
    model_reset();
    repeat (2) @(posedge dyn_clk);
    @(negedge dyn_clk);
    check_int("reset_state", int'({inc, dec, clr, repeating}), 0);
    reset = 1'b0;
    seq_begin();
    repeat (5) tick(1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      seq_begin();
      repeat (tbl[i].len) tick(tbl[i].up, tbl[i].dn);
      repeat (GAP) tick(1'b0, 1'b0);
      check_int($sformatf("tbl%0d_inc", i), n_inc, tbl[i].n_inc);
      check_int($sformatf("tbl%0d_dec", i), n_dec, tbl[i].n_dec);
      check_int($sformatf("tbl%0d_clr", i), n_clr, tbl[i].n_clr);
    end

    // Tap up: single inc exactly 7 edges after the press.
    seq_begin();
    repeat (4) tick(1'b1, 1'b0);
    repeat (16) tick(1'b0, 1'b0);
    check_int("tap_latency", first_inc, 7);

    // Down into REPEAT, then add up: one clr, nothing more until full release.
    seq_begin();
    repeat (20) tick(1'b0, 1'b1);
    check_int("chord_pre_dec", n_dec, 3);
    seq_begin();
    repeat (30) tick(1'b1, 1'b1);
    check_int("chord_dec", n_dec, 1);
    check_int("chord_clr", n_clr, 1);
    check_int("chord_inc", n_inc, 0);
    seq_begin();
    repeat (20) tick(1'b0, 1'b1);
    repeat (10) tick(1'b0, 1'b0);
    check_int("lock_pulses", n_inc + n_dec + n_clr, 0);
    seq_begin();
    repeat (4) tick(1'b1, 1'b0);
    repeat (GAP) tick(1'b0, 1'b0);
    check_int("after_lock_inc", n_inc, 1);
    check_int("after_lock_dec", n_dec, 0);

    // Up held, switch to down only while still in the initial delay.
    seq_begin();
    repeat (6) tick(1'b1, 1'b0);
    repeat (20) tick(1'b0, 1'b1);
    repeat (GAP) tick(1'b0, 1'b0);
    check_int("switch_inc", n_inc, 1);
    check_int("switch_first_dec", first_dec, 13);
    check_int("switch_second_dec", second_dec, 21);

    // Reset while repeating with up held; afterwards a fresh press.
    seq_begin();
    repeat (20) tick(1'b1, 1'b0);
    check_int("repeating_before_reset", int'(repeating), 1);
    do_reset();
    seq_begin();
    repeat (10) tick(1'b1, 1'b0);
    check_int("post_reset_latency", first_inc, 7);
    check_int("post_reset_inc", n_inc, 1);
    repeat (GAP) tick(1'b0, 1'b0);

    // Random segments, including short glitches and occasional resets.
    for (int s = 0; s < 250; s++) begin
      bit [1:0] pat;
      int       len;
      pat = 2'($urandom_range(0, 3));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                        : int'($urandom_range(1, 40));
      repeat (len) tick(pat[1], pat[0]);
      if ($urandom_range(0, 60) == 0) do_reset();
    end
    repeat (30) tick(1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
